hvac_zone_scheduler: RTL



---
 rtl/hvac_zone_scheduler_if.sv | 10 +
 rtl/hvac_zone_scheduler.sv | 95 +++++++++
 2 files changed

// File: rtl/hvac_zone_scheduler_if.sv
// hvac_zone_scheduler_if: zone request inputs and plant drive outputs of the scheduler.
interface hvac_zone_scheduler_if #(parameter int NZ = 4);
   logic [NZ-1:0] heat_req, cool_req, grant;
   logic plant_fault, heat_en, cool_en, fan_en, fault;
   logic [2:0] state;
   modport master(output heat_req, cool_req, plant_fault,
                  input grant, heat_en, cool_en, fan_en, fault, state);
   modport slave(input heat_req, cool_req, plant_fault,
                 output grant, heat_en, cool_en, fan_en, fault, state);
endinterface

// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: round-robin sharing of one plant with min/max run and fan purge.
module hvac_zone_scheduler #(
   parameter int NZ = 4,
   parameter int MIN_RUN = 8,
   parameter int MAX_RUN = 32,
   parameter int DEAD_TIME = 4
) (
   input logic clk,
   input logic reset,
   hvac_zone_scheduler_if.slave s
);
   localparam int PW = $clog2(NZ);
   localparam int RW = $clog2(MAX_RUN + 1);
   localparam int DW = $clog2(DEAD_TIME + 1);
   typedef enum logic [2:0] {IDLE = 3'd0, HEAT = 3'd1, COOL = 3'd2, PURGE = 3'd3, FAULT = 3'd4} state_t;
   state_t st;
   logic [NZ-1:0] grant, valid;
   logic heat_en, cool_en, fan_en, fault;
   logic [PW-1:0] rr_ptr, gidx, pick;
   logic [RW-1:0] run_cnt;
   logic [DW-1:0] purge_cnt;
   logic lost, others, rel;
   assign valid = s.heat_req ^ s.cool_req;
   assign others = |(valid & ~grant);
   assign lost = st == HEAT ? !(s.heat_req[gidx] && !s.cool_req[gidx])
                            : !(s.cool_req[gidx] && !s.heat_req[gidx]);
   assign rel = (lost && run_cnt >= RW'(MIN_RUN - 1)) || (run_cnt >= RW'(MAX_RUN - 1) && others);
   // descending scan so the closest valid zone at or after rr_ptr wins
   always_comb begin
      pick = '0;
      for (int k = NZ - 1; k >= 0; k--)
         if (valid[(int'(rr_ptr) + k) % NZ]) pick = PW'((int'(rr_ptr) + k) % NZ);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= IDLE;
         grant <= '0;
         heat_en <= 1'b0;
         cool_en <= 1'b0;
         fan_en <= 1'b0;
         fault <= 1'b0;
         rr_ptr <= '0;
         gidx <= '0;
         run_cnt <= '0;
         purge_cnt <= '0;
      end else if (s.plant_fault) begin
         st <= FAULT;
         grant <= '0;
         heat_en <= 1'b0;
         cool_en <= 1'b0;
         fan_en <= 1'b0;
         fault <= 1'b1;
      end else
         case (st)
            IDLE:
               if (|valid) begin
                  st <= s.heat_req[pick] ? HEAT : COOL;
                  grant <= NZ'(1) << pick;
                  heat_en <= s.heat_req[pick];
                  cool_en <= s.cool_req[pick];
                  fan_en <= 1'b1;
                  run_cnt <= '0;
                  gidx <= pick;
               end
            HEAT, COOL:
               if (rel) begin
                  st <= PURGE;
                  grant <= '0;
                  heat_en <= 1'b0;
                  cool_en <= 1'b0;
                  purge_cnt <= '0;
                  rr_ptr <= gidx == PW'(NZ - 1) ? '0 : gidx + 1'b1;
               end else if (run_cnt != RW'(MAX_RUN))
                  run_cnt <= run_cnt + 1'b1;
            PURGE:
               if (purge_cnt == DW'(DEAD_TIME - 1)) begin
                  st <= IDLE;
                  fan_en <= 1'b0;
               end else
                  purge_cnt <= purge_cnt + 1'b1;
            FAULT: begin
               st <= PURGE;
               fan_en <= 1'b1;
               fault <= 1'b0;
               purge_cnt <= '0;
            end
            default: st <= IDLE;
         endcase
   assign s.grant = grant;
   assign s.heat_en = heat_en;
   assign s.cool_en = cool_en;
   assign s.fan_en = fan_en;
   assign s.fault = fault;
   assign s.state = st;
endmodule
